mac_cluster_seq: RTL and testbench
==================================

# mac_cluster_seq

Job sequencer for one MAC quad-cluster. It accepts a command carrying mode, beat count and four initial accumulator values, then clears and configures the cluster. It streams operand beats into the cluster under valid/ready flow control, drains the cluster pipeline, and returns the four accumulator outputs through a result handshake. It sits between the fabric-side command/operand streams and the cluster's `en`/`rst`/`cfg`/operand pins.

## Interface
- `MIN_WIDTH`, default 8: operand width per MAC lane.
- `ACC_WIDTH`, default 32: accumulator width per MAC block.
- `CONF_WIDTH`, default 2: config field width; bits [1:0] are the mode.
- `LEN_W`, default 16: beat-count width.
- `PIPE_LAT`, default 3: enabled cycles from last operand beat until the cluster outputs are final; must be ≥1.
- `clk`  in  1  clock; all logic rises on the positive edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid` is also high.
- `cmd_mode`  in  2  00 single, 01 dual, 10 quad; 11 is reserved and coerced to 10.
- `cmd_len`  in  LEN_W  number of operand beats (0 allowed).
- `cmd_init`  in  4*ACC_WIDTH  initial accumulators; block k uses [k*ACC_WIDTH +: ACC_WIDTH].
- `op_valid` / `op_ready`  in/out  1  operand beat handshake.
- `op_a`, `op_b`  in  4*MIN_WIDTH  lane k operands at [k*MIN_WIDTH +: MIN_WIDTH].
- `mac_rst`  out  1  active-high pulse to the cluster; loads initial values from `mac_cfg`.
- `mac_en`  out  1  cluster enable.
- `mac_cfg`  out  4*ACC_WIDTH+CONF_WIDTH  {latched init, zero-extended mode}.
- `mac_a`, `mac_b`  out  4*MIN_WIDTH  cluster operands.
- `mac_out`  in  4*ACC_WIDTH  cluster outputs {out3,out2,out1,out0}.
- `res_valid` / `res_ready`  out/in  1  result handshake.
- `res_data`  out  4*ACC_WIDTH  captured `mac_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, RESULT.
- **IDLE**: `cmd_ready`=1. On `cmd_valid`: latch mode (coerced), len and init, then go to CLEAR.
- **CLEAR** lasts 1 cycle. `mac_rst`=1 and `mac_en`=0. Next state is RUN if len≠0, else DRAIN.
- **RUN**: `op_ready`=1.
  - `mac_en` = `op_valid`.
  - `mac_a`/`mac_b` = `op_a`/`op_b` when `op_valid`, else 0.
  - Each accepted beat decrements the remaining count.
  - The beat that brings the count to 0 moves the FSM to DRAIN.
  - A cycle with `op_valid`=0 is a bubble: `mac_en`=0 and the cluster is frozen.
- **DRAIN** lasts PIPE_LAT cycles. `mac_en`=1 with zero operands, which add zero. On the last DRAIN cycle, `res_data` ← `mac_out` and the FSM moves to RESULT.
- **RESULT**: `res_valid`=1 and `res_data` is held stable until `res_ready`. On the handshake the FSM returns to IDLE.
- `mac_cfg` holds the latched command value from CLEAR through RESULT. In IDLE it keeps the last value.
- Outside RUN, `op_ready`=0. Outside IDLE, `cmd_ready`=0, so there is no command queuing.
- Arithmetic: the beat counter is LEN_W bits and counts down with no wrap; the maximum is 2^LEN_W−1 beats. Accumulation width and overflow are defined by the cluster; this block does not inspect data.

## Timing
- Reset (`rst`=0, async) forces state IDLE, `cmd_ready`=1 after release, and all of the following to 0: `op_ready`, `mac_rst`, `mac_en`, `mac_cfg`, `mac_a`, `mac_b`, `res_valid`, `res_data`, `busy`, and the counter. Reset mid-job abandons the job; no result is produced.
- Command handshake in cycle T gives CLEAR in T+1 and RUN in T+2.
- With N beats and no bubbles, the last beat lands in T+N+1. DRAIN occupies T+N+2 .. T+N+1+PIPE_LAT. `res_valid` rises in T+N+2+PIPE_LAT.
- For len=0, DRAIN starts at T+2 and `res_valid` rises in T+2+PIPE_LAT.
- Handshake in RESULT at cycle R gives `res_valid`=0 and `cmd_ready`=1 in R+1. The minimum job-to-job gap is one IDLE cycle.
- `res_ready` held high early has no effect before RESULT.
- `mac_a`/`mac_b`/`mac_en` have a combinational path from `op_*` in RUN. All other outputs are registered.

## Test plan
- **Reset state**: assert `rst`=0 with random inputs → all outputs 0; after release, `cmd_ready`=1 and `busy`=0.
- **Quad dot product**: mode 10, len 4, init 0, `op_a`=`op_b` lanes all 1, PIPE_LAT 3, no bubbles → `mac_rst` pulses exactly once in T+1; `mac_en` high for 4+3 cycles; `res_valid` at T+9; `res_data` equals the cluster reference model.
- **Bubbles**: len 3 with `op_valid` pattern 1,0,0,1,1 → `mac_en` follows the pattern; exactly 3 beats are accepted; `res_valid` is 2 cycles later than the no-bubble case.
- **len=0 with init 5,6,7,8**, mode 00 → no `op_ready`; `res_valid` at T+2+PIPE_LAT; `res_data` equals the cluster output for the initial values.
- **Result backpressure**: hold `res_ready`=0 for 10 cycles → `res_valid` and `res_data` stay stable; `cmd_ready`=0 throughout; `cmd_ready`=1 one cycle after the handshake.
- **Mid-RUN reset and reserved mode**:
  - Assert `rst` after 2 of 8 beats → immediate zero outputs; a subsequent job completes correctly.
  - Mode 11 → `mac_cfg` mode field = 10.

Source files
------------

// File: rtl/mac_cluster_seq_if.sv
// Signal bundle around the MAC quad-cluster job sequencer: command, operand,
// cluster-side and result channels. master = sequencer view, slave = surrounding fabric/cluster.
interface mac_cluster_seq_if #(
  parameter int MIN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CONF_WIDTH = 2,
  parameter int LEN_W      = 16
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [1:0]                        cmd_mode;
  logic [LEN_W-1:0]                  cmd_len;
  logic [4*ACC_WIDTH-1:0]            cmd_init;
  logic                              op_valid;
  logic                              op_ready;
  logic [4*MIN_WIDTH-1:0]            op_a;
  logic [4*MIN_WIDTH-1:0]            op_b;
  logic                              mac_rst;
  logic                              mac_en;
  logic [4*ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg;
  logic [4*MIN_WIDTH-1:0]            mac_a;
  logic [4*MIN_WIDTH-1:0]            mac_b;
  logic [4*ACC_WIDTH-1:0]            mac_out;
  logic                              res_valid;
  logic                              res_ready;
  logic [4*ACC_WIDTH-1:0]            res_data;
  logic                              busy;

  modport master (
    input  cmd_valid, cmd_mode, cmd_len, cmd_init, op_valid, op_a, op_b, mac_out, res_ready,
    output cmd_ready, op_ready, mac_rst, mac_en, mac_cfg, mac_a, mac_b, res_valid, res_data, busy
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_len, cmd_init, op_valid, op_a, op_b, mac_out, res_ready,
    input  cmd_ready, op_ready, mac_rst, mac_en, mac_cfg, mac_a, mac_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_cluster_seq.sv
// Job sequencer for one MAC quad-cluster: command -> clear/config -> operand stream ->
// pipeline drain -> result handshake. Handshake outputs are registered from the next state.
module mac_cluster_seq #(
  parameter int MIN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CONF_WIDTH = 2,
  parameter int LEN_W      = 16,
  parameter int PIPE_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  mac_cluster_seq_if.master bus
);
  localparam int               DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]                        state;
  logic [2:0]                        state_nxt;
  logic [LEN_W-1:0]                  beat_cnt;
  logic [DRN_W-1:0]                  drain_cnt;
  logic                              cmd_ready_q;
  logic                              op_ready_q;
  logic                              mac_rst_q;
  logic                              res_valid_q;
  logic                              busy_q;
  logic [4*ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg_q;
  logic [4*ACC_WIDTH-1:0]            res_data_q;
  logic [1:0]                        mode_c;
  logic                              cmd_fire;
  logic                              beat_fire;
  logic                              res_fire;
  logic                              run_beat;

  // Reserved mode 11 is treated as quad.
  assign mode_c    = (bus.cmd_mode == 2'b11) ? 2'b10 : bus.cmd_mode;
  assign cmd_fire  = cmd_ready_q && bus.cmd_valid;
  assign beat_fire = op_ready_q && bus.op_valid;
  assign res_fire  = res_valid_q && bus.res_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_fire) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = (beat_cnt != '0) ? S_RUN : S_DRAIN;
      S_RUN:    if (beat_fire && (beat_cnt == LEN_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt == '0) state_nxt = S_RESULT;
      S_RESULT: if (res_fire) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      cmd_ready_q <= 1'b0;
      op_ready_q  <= 1'b0;
      mac_rst_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mac_cfg_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= (state_nxt == S_IDLE);
      op_ready_q  <= (state_nxt == S_RUN);
      mac_rst_q   <= (state_nxt == S_CLEAR);
      res_valid_q <= (state_nxt == S_RESULT);
      busy_q      <= (state_nxt != S_IDLE);

      if (cmd_fire) begin
        beat_cnt  <= bus.cmd_len;
        mac_cfg_q <= {bus.cmd_init, CONF_WIDTH'(mode_c)};
      end else if (beat_fire) begin
        beat_cnt  <= beat_cnt - LEN_W'(1);
      end

      // Drain counter runs PIPE_LAT-1 down to 0; the zero cycle captures the cluster outputs.
      if ((state != S_DRAIN) && (state_nxt == S_DRAIN)) begin
        drain_cnt <= DRN_LAST;
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt - DRN_W'(1);
      end

      if ((state == S_DRAIN) && (drain_cnt == '0)) begin
        res_data_q <= bus.mac_out;
      end
    end
  end

  // Operands pass straight through during RUN; drain cycles feed zeros that add nothing.
  assign run_beat      = (state == S_RUN) && bus.op_valid;
  assign bus.mac_en    = run_beat || (state == S_DRAIN);
  assign bus.mac_a     = run_beat ? bus.op_a : {4*MIN_WIDTH{1'b0}};
  assign bus.mac_b     = run_beat ? bus.op_b : {4*MIN_WIDTH{1'b0}};

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.mac_rst   = mac_rst_q;
  assign bus.mac_cfg   = mac_cfg_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mac_cluster_seq.sv
// Bench for mac_cluster_seq: a behavioural quad-MAC cluster sits on the cluster pins,
// and each job's result is compared with a dot product computed from the driven beats.
module tb_mac_cluster_seq;
  localparam int MIN_W  = 8;
  localparam int ACC_W  = 32;
  localparam int CONF_W = 2;
  localparam int LEN_W  = 16;
  localparam int P      = 3;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   vpat[$];

  mac_cluster_seq_if #(.MIN_WIDTH(MIN_W), .ACC_WIDTH(ACC_W), .CONF_WIDTH(CONF_W), .LEN_W(LEN_W)) bus ();

  mac_cluster_seq #(
    .MIN_WIDTH(MIN_W), .ACC_WIDTH(ACC_W), .CONF_WIDTH(CONF_W), .LEN_W(LEN_W), .PIPE_LAT(P)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cluster model: product stage plus P-2 delay stages, then accumulate; frozen when not enabled.
  logic signed [ACC_W-1:0] cl_acc  [4];
  logic signed [ACC_W-1:0] cl_pipe [P-1][4];

  function automatic logic signed [ACC_W-1:0] lane_prod(input logic [31:0] a, input logic [31:0] b,
                                                        input logic [1:0] md, input int k);
    logic signed [7:0] x;
    logic signed [7:0] y;
    x = a[k*8 +: 8];
    y = b[k*8 +: 8];
    if (k < (1 << md)) return ACC_W'(x) * ACC_W'(y);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cl_acc[k] <= '0;
        for (int s = 0; s < P-1; s++) cl_pipe[s][k] <= '0;
      end
    end else if (bus.mac_rst) begin
      for (int k = 0; k < 4; k++) begin
        cl_acc[k] <= bus.mac_cfg[CONF_W + k*ACC_W +: ACC_W];
        for (int s = 0; s < P-1; s++) cl_pipe[s][k] <= '0;
      end
    end else if (bus.mac_en) begin
      for (int k = 0; k < 4; k++) begin
        cl_pipe[0][k] <= lane_prod(bus.mac_a, bus.mac_b, bus.mac_cfg[1:0], k);
        for (int s = 1; s < P-1; s++) cl_pipe[s][k] <= cl_pipe[s-1][k];
        cl_acc[k] <= cl_acc[k] + cl_pipe[P-2][k];
      end
    end
  end

  assign bus.mac_out = {cl_acc[3], cl_acc[2], cl_acc[1], cl_acc[0]};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete job. bub: 0 no bubbles, 1 take op_valid from vpat, 2 random bubbles.
  task automatic do_job(input logic [1:0] mode, input int len, input logic [4*ACC_W-1:0] init,
                        input int bub, input bit ones, input int hold_res, output int lat);
    int                 racc[4];
    int                 nl, sent, idle_run, n_en, n_rst, cyc;
    bit                 v, comb_ok, rv_seen, stable_ok;
    logic [31:0]        a_v, b_v;
    logic [1:0]         mode_c;
    logic [4*ACC_W-1:0] exp_data, held;
    mode_c = (mode == 2'b11) ? 2'b10 : mode;
    nl     = (mode_c == 2'b00) ? 1 : (mode_c == 2'b01) ? 2 : 4;
    for (int k = 0; k < 4; k++) racc[k] = int'(init[k*ACC_W +: ACC_W]);

    bus.res_ready = (hold_res == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_init  = init;
    #1;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    n_rst = int'(bus.mac_rst);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'($urandom);
    bus.cmd_len   = LEN_W'($urandom);
    bus.cmd_init  = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("clear_ctrl", {bus.mac_rst, bus.mac_en, bus.busy, bus.cmd_ready, bus.op_ready}, 5'b10100);
    chk("clear_cfg", bus.mac_cfg, {init, CONF_W'(mode_c)});
    n_rst += int'(bus.mac_rst);
    tick();

    sent = 0; idle_run = 0; n_en = 0; comb_ok = 1; rv_seen = 0; cyc = 2;
    while (!rv_seen && cyc < 300) begin
      if (sent < len) begin
        if (bub == 1 && vpat.size() > 0) v = vpat.pop_front();
        else if (bub == 2)               v = ($urandom_range(0, 3) != 0);
        else                             v = 1'b1;
      end else begin
        v = 1'($urandom_range(0, 1));
      end
      a_v = ones ? 32'h01010101 : $urandom;
      b_v = ones ? 32'h01010101 : $urandom;
      bus.op_valid = v;
      bus.op_a     = a_v;
      bus.op_b     = b_v;
      #1;
      if (bus.res_valid === 1'b1) begin
        rv_seen = 1;
      end else begin
        if (bus.op_ready !== (sent < len)) comb_ok = 0;
        if (sent < len) begin
          if (bus.mac_en !== v) comb_ok = 0;
          if (bus.mac_a !== (v ? a_v : 32'h0) || bus.mac_b !== (v ? b_v : 32'h0)) comb_ok = 0;
          if (v) begin
            sent++;
            for (int k = 0; k < nl; k++)
              racc[k] += int'($signed(a_v[k*8 +: 8])) * int'($signed(b_v[k*8 +: 8]));
          end else begin
            idle_run++;
          end
        end else begin
          if (bus.mac_en !== 1'b1 || bus.mac_a !== 32'h0 || bus.mac_b !== 32'h0) comb_ok = 0;
        end
        n_en  += int'(bus.mac_en);
        n_rst += int'(bus.mac_rst);
        tick();
        cyc++;
      end
    end
    bus.op_valid = 1'b0;
    lat = cyc;
    exp_data = {racc[3], racc[2], racc[1], racc[0]};
    chk("res_valid_seen", rv_seen, 1);
    chk("res_latency", cyc, 2 + len + idle_run + P);
    chk("run_drain_comb", comb_ok, 1);
    chk("mac_en_cycles", n_en, len + P);
    chk("mac_rst_once", n_rst, 1);
    chk("res_data", bus.res_data, exp_data);
    chk("result_ctrl", {bus.busy, bus.cmd_ready, bus.op_ready}, 3'b100);

    held = bus.res_data;
    stable_ok = 1;
    for (int i = 0; i < hold_res; i++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.cmd_ready !== 1'b0) stable_ok = 0;
    end
    if (hold_res > 0) chk("res_backpressure_stable", stable_ok, 1);
    bus.res_ready = 1'b1;
    tick();
    chk("post_handshake", {bus.res_valid, bus.cmd_ready, bus.busy}, 3'b010);
    chk("cfg_hold_idle", bus.mac_cfg, {init, CONF_W'(mode_c)});
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 2'($urandom);
    bus.cmd_len   = LEN_W'($urandom);
    bus.cmd_init  = {$urandom, $urandom, $urandom, $urandom};
    bus.op_valid  = 1'b1;
    bus.op_a      = $urandom;
    bus.op_b      = $urandom;
    bus.res_ready = 1'($urandom_range(0, 1));
    tick();
    tick();
    chk("reset_ctrl", {bus.cmd_ready, bus.op_ready, bus.mac_rst, bus.mac_en, bus.res_valid, bus.busy}, 6'b0);
    chk("reset_ops", {bus.mac_a, bus.mac_b}, 64'h0);
    chk("reset_cfg", bus.mac_cfg, 0);
    chk("reset_res_data", bus.res_data, 0);
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_ready", {bus.cmd_ready, bus.busy}, 2'b10);

    // Quad dot product with all-ones lanes.
    do_job(2'b10, 4, '0, 0, 1'b1, 0, lat);
    chk("quad_latency", lat, 9);
    chk("quad_result", bus.res_data, {4{32'd4}});

    // Bubbles: valid pattern 1,0,0,1,1 for three beats.
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_job(2'b01, 3, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 0, lat);
    chk("bubble_latency", lat, 3 + 2 + P + 2);

    // Zero-length job returns the initial values.
    do_job(2'b00, 0, {32'd8, 32'd7, 32'd6, 32'd5}, 0, 1'b0, 0, lat);
    chk("len0_latency", lat, 2 + P);
    chk("len0_result", bus.res_data, {32'd8, 32'd7, 32'd6, 32'd5});

    // Result backpressure.
    do_job(2'b10, 5, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 10, lat);

    // Reset after two of eight beats abandons the job.
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 2'b10;
    bus.cmd_len   = LEN_W'(8);
    bus.cmd_init  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ctrl", {bus.cmd_ready, bus.op_ready, bus.mac_rst, bus.mac_en, bus.res_valid, bus.busy}, 6'b0);
    chk("midrun_rst_ops", {bus.mac_a, bus.mac_b}, 64'h0);
    chk("midrun_rst_cfg", bus.mac_cfg, 0);
    bus.op_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("midrun_release", {bus.cmd_ready, bus.busy, bus.res_valid}, 3'b100);
    do_job(2'b10, 6, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 0, lat);

    // Reserved mode coerces to quad.
    do_job(2'b11, 4, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 0, lat);
    chk("mode11_cfg_field", bus.mac_cfg[1:0], 2'b10);

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      do_job(2'($urandom_range(0, 3)), $urandom_range(0, 7),
             {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, $urandom_range(0, 3), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
